vram_cmd_executor: RTL and testbench
====================================

// Module: vram_cmd_executor
// PURPOSE
//   Responder for show_info_cmd_t commands issued by the CPU debug/info sequencer.
//   Accepts one command per handshake. Optionally fetches the source byte from memory.
//   Renders the byte as a raw character or as two hex ASCII characters, and writes
//   the characters into text VRAM. It sits between the CPU control FSM and the VRAM
//   write port / memory read port.
// PARAMETERS
//   MEM_LATENCY  2   cycles from mem_re high to mem_rdata valid (legal range 1..7)
// PORTS
//   clk         in   1   system clock; single clock domain
//   rst         in   1   synchronous, active-high reset
//   cmd_valid   in   1   command present on cmd
//   cmd_ready   out  1   executor idle, will accept cmd this cycle
//   cmd         in   32  show_info_cmd_t {v_ada[9:0],v_din_t[3:0],v_din[7:0],diff[7:0],vram_write,mem_read}
//   mem_base    in   16  base address for memory-sourced bytes; sampled at accept
//   mem_re      out  1   memory read strobe, one cycle
//   mem_addr    out  16  memory read address
//   mem_rdata   in   8   memory read data
//   vram_we     out  1   VRAM write enable
//   vram_addr   out  10  VRAM character address
//   vram_din    out  8   VRAM character data
//   busy        out  1   command in progress (= !cmd_ready)
//   done        out  1   one-cycle pulse: current command completed
// BEHAVIOUR
//   Reset
//     - FSM goes to IDLE.
//     - cmd_ready=1 in IDLE after reset; all other outputs 0; latched command cleared.
//     - Reset mid-command aborts it immediately; no further mem_re or vram_we is issued.
//   Handshake
//     - Accept occurs at the edge where cmd_valid && cmd_ready.
//     - cmd and mem_base are latched at accept.
//     - cmd_ready is 1 only in IDLE. cmd_valid is ignored while busy, and the command is not queued.
//   Source byte (src)
//     - mem_read=1: src = mem_rdata read from mem_addr = mem_base + {8'h00,diff}, modulo 2^16.
//     - mem_read=0: src = v_din, with no memory access.
//   Render, selected by v_din_t
//     - 0: RAW. One write: vram_addr=v_ada, vram_din=src.
//     - 1: HEX. Two writes.
//         - v_ada   <= to_hexchar(src[7:4])
//         - v_ada+1 <= to_hexchar(src[3:0])
//         - to_hexchar maps 0-9 to 8'h30+n and A-F to 8'h41+(n-10), uppercase.
//     - 2..15: reserved, treated as RAW.
//   Address arithmetic
//     - v_ada+1 is 10-bit and wraps: 10'h3FF+1 -> 10'h000.
//   vram_write=0 disables all VRAM writes
//     - The memory read is still performed when mem_read=1.
//     - The command still completes with done.
//   States: IDLE, MEM_REQ, MEM_WAIT, WR_HI, WR_LO, DONE
//     - IDLE: on accept, go to MEM_REQ if mem_read, else WR_HI.
//     - MEM_REQ: mem_re=1 and mem_addr valid for exactly one cycle, then MEM_WAIT.
//     - MEM_WAIT
//         - Wait counter is 3 bits.
//         - mem_rdata is captured exactly MEM_LATENCY cycles after the mem_re cycle.
//         - Then go to WR_HI.
//     - WR_HI
//         - vram_we=vram_write.
//         - Emits the RAW char, or the high hex char.
//         - Goes to WR_LO if HEX, else DONE.
//     - WR_LO: vram_we=vram_write, low hex char at v_ada+1; then DONE.
//     - DONE: done=1 for one cycle, then IDLE.
//   Timing (accept edge = cycle 0, states listed per cycle)
//     - RAW, no mem: cycle 1 WR_HI; cycle 2 DONE; cycle 3 IDLE with ready=1.
//     - HEX, no mem: cycle 1 WR_HI; cycle 2 WR_LO; cycle 3 DONE.
//     - HEX, mem:
//         - cycle 1 MEM_REQ; data captured at cycle 1+MEM_LATENCY.
//         - WR_HI at cycle 2+MEM_LATENCY; WR_LO at cycle 3+MEM_LATENCY; DONE at cycle 4+MEM_LATENCY.
//   Output hold
//     - vram_addr, vram_din and mem_addr hold their last values when strobes are low.
//     - vram_we and mem_re are never high outside the states above.
// TESTING
//   1. RAW literal: cmd{v_ada=10'h005,v_din_t=0,v_din=8'h41,vram_write=1,mem_read=0}
//      -> single write 0x005<=8'h41; done at cycle 2; ready at cycle 3.
//   2. HEX literal: v_ada=10'h020, v_din_t=1, v_din=8'hA7
//      -> writes 0x020<=8'h41 ('A') then 0x021<=8'h37 ('7') on consecutive cycles.
//   3. Memory HEX: mem_base=16'h0200, diff=8'h10, mem_read=1, MEM_LATENCY=2; memory[0x0210]=8'h3C
//      -> mem_re once with addr 0x0210; writes '3'(8'h33), 'C'(8'h43); done at cycle 6.
//   4. Wrap cases
//      -> v_ada=10'h3FF HEX v_din=8'h09: writes 0x3FF<='0', 0x000<='9'.
//      -> mem_base=16'hFFF8, diff=8'h10: mem_addr=16'h0008.
//   5. vram_write=0 with mem_read=1 -> one mem_re, zero vram_we, done pulse still issued.
//   6. Back-to-back cmd_valid held high and reset during WR_HI of a HEX cmd
//      -> second cmd is taken only when ready=1.
//      -> after reset, no WR_LO write; outputs 0; ready=1 the cycle after reset deasserts.

Source files
------------

// File: rtl/vram_cmd_executor.sv
// Executes show_info commands: optional memory fetch of one byte, then renders it
// as a raw character or two uppercase hex characters into text VRAM.
module vram_cmd_executor #(
  parameter int unsigned MEM_LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd,
  input  logic [15:0] mem_base,
  output logic        mem_re,
  output logic [15:0] mem_addr,
  input  logic [7:0]  mem_rdata,
  output logic        vram_we,
  output logic [9:0]  vram_addr,
  output logic [7:0]  vram_din,
  output logic        busy,
  output logic        done
);

  localparam int unsigned ADDR_W  = 16;
  localparam int unsigned VADDR_W = 10;
  localparam int unsigned DATA_W  = 8;
  localparam int unsigned WAIT_W  = 3;

  typedef enum logic [2:0] {
    IDLE,
    MEM_REQ,
    MEM_WAIT,
    WR_HI,
    WR_LO,
    DONE
  } state_t;

  typedef struct packed {
    logic [VADDR_W-1:0] v_ada;
    logic [3:0]         v_din_t;
    logic [DATA_W-1:0]  v_din;
    logic [7:0]         diff;
    logic               vram_write;
    logic               mem_read;
  } cmd_t;

  function automatic logic [DATA_W-1:0] to_hexchar(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  cmd_t               cmd_in;
  state_t             state_q, state_d;
  cmd_t               cmd_q, cmd_d;
  logic [ADDR_W-1:0]  base_q, base_d;
  logic [DATA_W-1:0]  src_q, src_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic               hex_d;

  logic               cmd_ready_d, busy_d, done_d;
  logic               mem_re_d, vram_we_d;
  logic [ADDR_W-1:0]  mem_addr_d;
  logic [VADDR_W-1:0] vram_addr_d;
  logic [DATA_W-1:0]  vram_din_d;

  assign cmd_in = cmd_t'(cmd);

  // State and registered outputs; outputs are precomputed for the next state
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cmd_q     <= '0;
      base_q    <= '0;
      src_q     <= '0;
      wait_q    <= '0;
      cmd_ready <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      mem_re    <= 1'b0;
      mem_addr  <= '0;
      vram_we   <= 1'b0;
      vram_addr <= '0;
      vram_din  <= '0;
    end else begin
      state_q   <= state_d;
      cmd_q     <= cmd_d;
      base_q    <= base_d;
      src_q     <= src_d;
      wait_q    <= wait_d;
      cmd_ready <= cmd_ready_d;
      busy      <= busy_d;
      done      <= done_d;
      mem_re    <= mem_re_d;
      mem_addr  <= mem_addr_d;
      vram_we   <= vram_we_d;
      vram_addr <= vram_addr_d;
      vram_din  <= vram_din_d;
    end
  end

  // Next state, then the outputs that the next state presents
  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    base_d      = base_q;
    src_d       = src_q;
    wait_d      = wait_q;
    mem_re_d    = 1'b0;
    mem_addr_d  = mem_addr;
    vram_we_d   = 1'b0;
    vram_addr_d = vram_addr;
    vram_din_d  = vram_din;
    done_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          cmd_d  = cmd_in;
          base_d = mem_base;
          if (cmd_in.mem_read) begin
            state_d = MEM_REQ;
          end else begin
            src_d   = cmd_in.v_din;
            state_d = WR_HI;
          end
        end
      end
      MEM_REQ: begin
        wait_d  = WAIT_W'(1);
        state_d = MEM_WAIT;
      end
      MEM_WAIT: begin
        if (wait_q == WAIT_W'(MEM_LATENCY)) begin
          src_d   = mem_rdata;
          state_d = WR_HI;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      WR_HI:   state_d = (cmd_q.v_din_t == 4'd1) ? WR_LO : DONE;
      WR_LO:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    hex_d = (cmd_d.v_din_t == 4'd1);

    case (state_d)
      MEM_REQ: begin
        mem_re_d   = 1'b1;
        mem_addr_d = base_d + {8'h00, cmd_d.diff};
      end
      WR_HI: begin
        if (cmd_d.vram_write) begin
          vram_we_d   = 1'b1;
          vram_addr_d = cmd_d.v_ada;
          vram_din_d  = hex_d ? to_hexchar(src_d[7:4]) : src_d;
        end
      end
      WR_LO: begin
        if (cmd_d.vram_write) begin
          vram_we_d   = 1'b1;
          vram_addr_d = cmd_d.v_ada + VADDR_W'(1);
          vram_din_d  = to_hexchar(src_d[3:0]);
        end
      end
      DONE:    done_d = 1'b1;
      default: ;
    endcase

    cmd_ready_d = (state_d == IDLE);
    busy_d      = (state_d != IDLE);
  end

endmodule

// File: tb/tb_vram_cmd_executor.sv
// Self-checking bench for vram_cmd_executor: cycle-level reference model driven by
// per-command timing arithmetic, directed literal cases, then randomized traffic.
module tb_vram_cmd_executor;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd;
  logic [15:0] mem_base;
  logic        mem_re;
  logic [15:0] mem_addr;
  logic [7:0]  mem_rdata;
  logic        vram_we;
  logic [9:0]  vram_addr;
  logic [7:0]  vram_din;
  logic        busy;
  logic        done;

  always #5 clk = ~clk;

  vram_cmd_executor #(.MEM_LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd(cmd),
    .mem_base(mem_base), .mem_re(mem_re), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .vram_we(vram_we), .vram_addr(vram_addr), .vram_din(vram_din), .busy(busy), .done(done)
  );

  // Memory: data appears exactly LAT cycles after the mem_re cycle, noise otherwise
  logic [7:0]  mem [65536];
  logic        hist_re [8] = '{default: 1'b0};
  logic [15:0] hist_a  [8] = '{default: 16'h0};
  always @(negedge clk) begin
    for (int i = 7; i > 0; i--) begin
      hist_re[i] = hist_re[i-1];
      hist_a[i]  = hist_a[i-1];
    end
    hist_re[0] = mem_re;
    hist_a[0]  = mem_addr;
    mem_rdata  = hist_re[LAT] ? mem[hist_a[LAT]] : 8'($urandom);
  end

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // Reference model state
  bit          m_valid = 1'b0;
  bit          m_active = 1'b0;
  int          m_start = 0;
  logic [31:0] m_cmd = '0;
  logic [15:0] m_base = '0;
  logic [9:0]  h_vaddr = '0;
  logic [7:0]  h_vdin = '0;
  logic [15:0] h_maddr = '0;

  // Observation log for directed cases
  logic [9:0]  wr_a [$];
  logic [7:0]  wr_d [$];
  int          n_re = 0;
  logic [15:0] re_addr = '0;
  int          n_done = 0;
  int          done_cyc = 0;
  int          acc_start = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] hexc(input logic [3:0] n);
    string s;
    s = "0123456789ABCDEF";
    return s[n];
  endfunction

  function automatic logic [31:0] mk(input logic [9:0] a, input logic [3:0] t, input logic [7:0] v,
                                     input logic [7:0] df, input logic vw, input logic mr);
    return {a, t, v, df, vw, mr};
  endfunction

  // Compare this cycle's outputs with the model, log events, then advance the model
  task automatic model_step();
    logic        e_re, e_we, e_done, mr, vw, hex;
    logic [9:0]  ada;
    logic [7:0]  src;
    logic [15:0] maddr;
    int          rel, h, d;
    e_re = 1'b0; e_we = 1'b0; e_done = 1'b0;
    rel = 0; h = 0; d = 0;
    mr    = m_cmd[0];
    vw    = m_cmd[1];
    hex   = (m_cmd[21:18] == 4'd1);
    ada   = m_cmd[31:22];
    maddr = m_base + {8'h00, m_cmd[9:2]};
    src   = mr ? mem[maddr] : m_cmd[17:10];
    if (m_active) begin
      rel = cyc - m_start + 1;
      h   = mr ? 2 + LAT : 1;
      d   = hex ? h + 2 : h + 1;
      if (mr && rel == 1) begin
        e_re = 1'b1;
        h_maddr = maddr;
      end
      if (vw && rel == h) begin
        e_we = 1'b1;
        h_vaddr = ada;
        h_vdin  = hex ? hexc(src[7:4]) : src;
      end
      if (vw && hex && rel == h + 1) begin
        e_we = 1'b1;
        h_vaddr = ada + 10'd1;
        h_vdin  = hexc(src[3:0]);
      end
      e_done = (rel == d);
    end
    if (m_valid) begin
      chk("cmd_ready", cmd_ready, !m_active);
      chk("busy", busy, m_active);
      chk("mem_re", mem_re, e_re);
      chk("mem_addr", mem_addr, h_maddr);
      chk("vram_we", vram_we, e_we);
      chk("vram_addr", vram_addr, h_vaddr);
      chk("vram_din", vram_din, h_vdin);
      chk("done", done, e_done);
    end
    if (vram_we) begin
      wr_a.push_back(vram_addr);
      wr_d.push_back(vram_din);
    end
    if (mem_re) begin
      n_re++;
      re_addr = mem_addr;
    end
    if (done) begin
      n_done++;
      done_cyc = cyc;
    end
    if (rst) begin
      m_valid = 1'b1; m_active = 1'b0;
      h_vaddr = '0; h_vdin = '0; h_maddr = '0;
    end else if (m_valid) begin
      if (m_active && rel == d) begin
        m_active = 1'b0;
      end else if (!m_active && cmd_valid) begin
        m_active = 1'b1; m_cmd = cmd; m_base = mem_base; m_start = cyc + 1;
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    model_step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic clear_log();
    wr_a.delete(); wr_d.delete();
    n_re = 0; n_done = 0; re_addr = '0; done_cyc = 0;
  endtask

  // Issue one command from idle and wait (bounded) for its done pulse
  task automatic run(input logic [31:0] c, input logic [15:0] b);
    int budget;
    clear_log();
    cmd_valid = 1'b1; cmd = c; mem_base = b;
    tick();
    acc_start = m_start;
    cmd_valid = 1'b0; cmd = $urandom; mem_base = 16'($urandom);
    budget = 40;
    while (n_done == 0 && budget > 0) begin
      tick();
      budget--;
    end
    if (n_done == 0) chk("done_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    mem[16'h0210] = 8'h3C;
    mem[16'h0008] = 8'h5E;
    rst = 1'b1; cmd_valid = 1'b0; cmd = '0; mem_base = '0;
    repeat (3) tick();
    chk("reset_ready", cmd_ready, 1'b1);
    chk("reset_vram_we", vram_we, 1'b0);
    chk("reset_done", done, 1'b0);
    rst = 1'b0;
    tick();

    // RAW literal
    run(mk(10'h005, 4'd0, 8'h41, 8'h00, 1'b1, 1'b0), 16'h0000);
    chk("t1_nwr", wr_a.size(), 1);
    chk("t1_addr", wr_a[0], 10'h005);
    chk("t1_data", wr_d[0], 8'h41);
    chk("t1_done_cyc", done_cyc - acc_start + 1, 2);
    chk("t1_ready_c3", cmd_ready, 1'b1);

    // HEX literal
    run(mk(10'h020, 4'd1, 8'hA7, 8'h00, 1'b1, 1'b0), 16'h0000);
    chk("t2_nwr", wr_a.size(), 2);
    chk("t2_a0", wr_a[0], 10'h020);
    chk("t2_d0", wr_d[0], 8'h41);
    chk("t2_a1", wr_a[1], 10'h021);
    chk("t2_d1", wr_d[1], 8'h37);
    chk("t2_done_cyc", done_cyc - acc_start + 1, 3);

    // Memory-sourced HEX
    run(mk(10'h100, 4'd1, 8'h00, 8'h10, 1'b1, 1'b1), 16'h0200);
    chk("t3_nre", n_re, 1);
    chk("t3_raddr", re_addr, 16'h0210);
    chk("t3_d0", wr_d[0], 8'h33);
    chk("t3_d1", wr_d[1], 8'h43);
    chk("t3_done_cyc", done_cyc - acc_start + 1, 6);

    // VRAM address wrap, memory address wrap
    run(mk(10'h3FF, 4'd1, 8'h09, 8'h00, 1'b1, 1'b0), 16'h0000);
    chk("t4_a0", wr_a[0], 10'h3FF);
    chk("t4_d0", wr_d[0], 8'h30);
    chk("t4_a1", wr_a[1], 10'h000);
    chk("t4_d1", wr_d[1], 8'h39);
    run(mk(10'h010, 4'd0, 8'h00, 8'h10, 1'b1, 1'b1), 16'hFFF8);
    chk("t4_raddr", re_addr, 16'h0008);
    chk("t4_rawmem", wr_d[0], 8'h5E);

    // Memory read with VRAM writes disabled
    run(mk(10'h050, 4'd1, 8'h00, 8'h04, 1'b0, 1'b1), 16'h0100);
    chk("t5_nre", n_re, 1);
    chk("t5_nwr", wr_a.size(), 0);
    chk("t5_ndone", n_done, 1);

    // cmd_valid held high: a RAW command every third cycle
    clear_log();
    for (int i = 0; i < 30; i++) begin
      cmd_valid = 1'b1;
      cmd = mk(10'(i * 7), 4'd0, 8'(i), 8'h00, 1'b1, 1'b0);
      tick();
    end
    cmd_valid = 1'b0;
    chk("t6_ndone", n_done, 10);
    chk("t6_nwr", wr_a.size(), 10);

    // Reset during WR_HI of a HEX command
    cmd_valid = 1'b1; cmd = mk(10'h200, 4'd1, 8'h5A, 8'h00, 1'b1, 1'b0);
    tick();
    cmd_valid = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    clear_log();
    chk("t6_rst_we", vram_we, 1'b0);
    chk("t6_rst_addr", vram_addr, 10'h000);
    chk("t6_rst_ready", cmd_ready, 1'b1);
    repeat (5) tick();
    chk("t6_rst_nwr", wr_a.size(), 0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic [3:0] t;
      t = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'($urandom_range(0, 1));
      cmd_valid = ($urandom_range(0, 2) != 0);
      cmd = mk(10'($urandom), t, 8'($urandom), 8'($urandom),
               ($urandom_range(0, 4) != 0), 1'($urandom));
      mem_base = 16'($urandom);
      rst = ($urandom_range(0, 149) == 0);
      tick();
    end
    rst = 1'b0; cmd_valid = 1'b0;
    repeat (12) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
